// File: rtl/touch_resp_pkg.sv
// Shared definitions for the touchscreen ADC responder: channel codes,
// FSM state encoding and control-byte field positions.
package touch_resp_pkg;

   localparam logic [2:0] CH_X  = 3'b101;
   localparam logic [2:0] CH_Y  = 3'b001;
   localparam logic [2:0] CH_Z1 = 3'b011;
   localparam logic [2:0] CH_Z2 = 3'b100;

   localparam int unsigned CMD_S_BIT    = 7;
   localparam int unsigned CMD_A_HI     = 6;
   localparam int unsigned CMD_A_LO     = 4;
   localparam int unsigned CMD_MODE_BIT = 3;
   localparam int unsigned CMD_SER_BIT  = 2;
   localparam int unsigned CMD_PD_HI    = 1;
   localparam int unsigned CMD_PD_LO    = 0;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HUNT  = 3'd1,
      CMD   = 3'd2,
      BUSYW = 3'd3,
      BUSY  = 3'd4,
      DATA  = 3'd5
   } resp_state_e;

endpackage

// File: rtl/touch_resp_sync.sv
// Multi-flop synchronizer for one serial input with rise/fall detection
// of the synchronized level against its previous value.
module touch_resp_sync #(
   parameter int unsigned STAGES  = 2,
   parameter logic        RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rstb,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain_q, chain_d;
   logic              prev_q, prev_d;

   always_comb begin
      chain_d = {chain_q[STAGES-2:0], d};
      prev_d  = chain_q[STAGES-1];
   end

   always_ff @(posedge clk) begin
      if (!rstb) begin
         chain_q <= {STAGES{RST_VAL}};
         prev_q  <= RST_VAL;
      end else begin
         chain_q <= chain_d;
         prev_q  <= prev_d;
      end
   end

   assign q    = chain_q[STAGES-1];
   assign rise = chain_q[STAGES-1] & ~prev_q;
   assign fall = ~chain_q[STAGES-1] & prev_q;

endmodule

// File: rtl/touch_adc_responder.sv
// Responder side of the touchscreen ADC serial link: decodes the control
// byte, returns BUSY and the selected result. Option: TOUCH_RESP_PENIRQ_EN.
module touch_adc_responder
   import touch_resp_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DATA_W      = 12
) (
   input  logic              cclk,
   input  logic              rstb,
   input  logic              touch_csb,
   input  logic              touch_clk,
   input  logic              touch_data_in,
   output logic              touch_data_out,
   output logic              touch_busy,
   input  logic [DATA_W-1:0] x_val,
   input  logic [DATA_W-1:0] y_val,
   input  logic [DATA_W-1:0] z1_val,
   input  logic [DATA_W-1:0] z2_val,
`ifdef TOUCH_RESP_PENIRQ_EN
   input  logic              pen_down,
   output logic              touch_penirq_n,
`endif
   output logic [7:0]        last_cmd,
   output logic              cmd_strobe
);

   localparam int unsigned CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] IDX_MSB  = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] IDX_LSB8 = CNT_W'(DATA_W - 8);

   logic csb_s, csb_rise_unused, csb_fall_unused;
   logic clk_s_unused, clk_rise, clk_fall;
   logic din_s, din_rise_unused, din_fall_unused;

   touch_resp_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csb (
      .clk (cclk), .rstb (rstb), .d (touch_csb),
      .q (csb_s), .rise (csb_rise_unused), .fall (csb_fall_unused)
   );

   touch_resp_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
      .clk (cclk), .rstb (rstb), .d (touch_clk),
      .q (clk_s_unused), .rise (clk_rise), .fall (clk_fall)
   );

   touch_resp_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_din (
      .clk (cclk), .rstb (rstb), .d (touch_data_in),
      .q (din_s), .rise (din_rise_unused), .fall (din_fall_unused)
   );

   resp_state_e       state_q, state_d;
   logic [6:0]        shift_q, shift_d;
   logic [2:0]        bitcnt_q, bitcnt_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic [CNT_W-1:0]  bitidx_q, bitidx_d;
   logic              mode8_q, mode8_d;
   logic [7:0]        last_cmd_q, last_cmd_d;
   logic              cmd_strobe_q, cmd_strobe_d;
   logic              busy_q, busy_d;
   logic              dout_q, dout_d;

   logic [7:0]        cmd_byte;
   logic [DATA_W-1:0] sel_val;
   logic [CNT_W-1:0]  lsb_idx;

   always_comb begin
      cmd_byte = {shift_q, din_s};
      unique case (cmd_byte[CMD_A_HI:CMD_A_LO])
         CH_X:    sel_val = x_val;
         CH_Y:    sel_val = y_val;
         CH_Z1:   sel_val = z1_val;
         CH_Z2:   sel_val = z2_val;
         default: sel_val = '0;
      endcase
      lsb_idx = mode8_q ? IDX_LSB8 : '0;
   end

   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      bitcnt_d     = bitcnt_q;
      result_d     = result_q;
      bitidx_d     = bitidx_q;
      mode8_d      = mode8_q;
      last_cmd_d   = last_cmd_q;
      cmd_strobe_d = 1'b0;
      busy_d       = busy_q;
      dout_d       = dout_q;

      if (csb_s) begin
         state_d = IDLE;
         busy_d  = 1'b0;
         dout_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: state_d = HUNT;
            HUNT: begin
               // The start bit seeds the shifter; it reaches bit 7 after 7 more shifts.
               if (clk_rise && din_s) begin
                  shift_d  = 7'h01;
                  bitcnt_d = 3'd1;
                  state_d  = CMD;
               end
            end
            CMD: begin
               if (clk_rise) begin
                  if (bitcnt_q == 3'd7) begin
                     last_cmd_d   = cmd_byte;
                     cmd_strobe_d = 1'b1;
                     result_d     = sel_val;
                     mode8_d      = cmd_byte[CMD_MODE_BIT];
                     state_d      = BUSYW;
                  end else begin
                     shift_d  = {shift_q[5:0], din_s};
                     bitcnt_d = bitcnt_q + 3'd1;
                  end
               end
            end
            BUSYW: begin
               if (clk_fall) begin
                  busy_d  = 1'b1;
                  dout_d  = 1'b0;
                  state_d = BUSY;
               end
            end
            BUSY: begin
               if (clk_fall) begin
                  busy_d   = 1'b0;
                  dout_d   = result_q[DATA_W-1];
                  bitidx_d = IDX_MSB;
                  state_d  = DATA;
               end
            end
            DATA: begin
               // bitidx_q is the result bit currently on the wire.
               if (clk_fall) begin
                  if (bitidx_q == lsb_idx) begin
                     dout_d  = 1'b0;
                     state_d = HUNT;
                  end else begin
                     bitidx_d = bitidx_q - 1'b1;
                     dout_d   = result_q[bitidx_q - 1'b1];
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge cclk) begin
      if (!rstb) begin
         state_q      <= IDLE;
         shift_q      <= '0;
         bitcnt_q     <= '0;
         result_q     <= '0;
         bitidx_q     <= '0;
         mode8_q      <= 1'b0;
         last_cmd_q   <= '0;
         cmd_strobe_q <= 1'b0;
         busy_q       <= 1'b0;
         dout_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         bitcnt_q     <= bitcnt_d;
         result_q     <= result_d;
         bitidx_q     <= bitidx_d;
         mode8_q      <= mode8_d;
         last_cmd_q   <= last_cmd_d;
         cmd_strobe_q <= cmd_strobe_d;
         busy_q       <= busy_d;
         dout_q       <= dout_d;
      end
   end

   assign touch_data_out = dout_q;
   assign touch_busy     = busy_q;
   assign last_cmd       = last_cmd_q;
   assign cmd_strobe     = cmd_strobe_q;

`ifdef TOUCH_RESP_PENIRQ_EN
   logic penirq_q, penirq_d;

   always_comb begin
      penirq_d = 1'b1;
      if ((state_d != BUSYW) && (state_d != BUSY) && (state_d != DATA) &&
          (last_cmd_q[CMD_PD_HI:CMD_PD_LO] == 2'b00)) begin
         penirq_d = ~pen_down;
      end
   end

   always_ff @(posedge cclk) begin
      if (!rstb) begin
         penirq_q <= 1'b1;
      end else begin
         penirq_q <= penirq_d;
      end
   end

   assign touch_penirq_n = penirq_q;
`endif

endmodule

// File: tb/tb_touch_adc_responder.sv
// Directed, table-driven bench for touch_adc_responder acting as a DCLK initiator.
module tb_touch_adc_responder;

   localparam int HALF = 16;
   localparam int NRISE = 24;

   logic        cclk = 1'b0;
   logic        rstb;
   logic        touch_csb;
   logic        touch_clk;
   logic        touch_data_in;
   logic        touch_data_out;
   logic        touch_busy;
   logic [11:0] x_val, y_val, z1_val, z2_val;
   logic [7:0]  last_cmd;
   logic        cmd_strobe;
`ifdef TOUCH_RESP_PENIRQ_EN
   logic        pen_down;
   logic        touch_penirq_n;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int strobe_cnt = 0;

   always #5 cclk = ~cclk;

   touch_adc_responder #(.SYNC_STAGES(2), .DATA_W(12)) dut (
      .cclk           (cclk),
      .rstb           (rstb),
      .touch_csb      (touch_csb),
      .touch_clk      (touch_clk),
      .touch_data_in  (touch_data_in),
      .touch_data_out (touch_data_out),
      .touch_busy     (touch_busy),
      .x_val          (x_val),
      .y_val          (y_val),
      .z1_val         (z1_val),
      .z2_val         (z2_val),
`ifdef TOUCH_RESP_PENIRQ_EN
      .pen_down       (pen_down),
      .touch_penirq_n (touch_penirq_n),
`endif
      .last_cmd       (last_cmd),
      .cmd_strobe     (cmd_strobe)
   );

   always @(negedge cclk) if (cmd_strobe === 1'b1) strobe_cnt++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_cc(input int n);
      repeat (n) @(negedge cclk);
   endtask

   // Samples DOUT/BUSY just before each rise; sample k lands in bit NRISE-k.
   task automatic xfer(input logic [7:0] cmd, input int lead, input int nclk,
                       output logic [23:0] dcap, output logic [23:0] bcap,
                       output logic [23:0] pcap);
      logic bitv;
      dcap = '0; bcap = '0; pcap = '0;
      touch_csb = 1'b0;
      for (int k = 1; k <= nclk; k++) begin
         if (k <= lead || k > lead + 8) bitv = 1'b0;
         else bitv = cmd[7 - (k - 1 - lead)];
         touch_data_in = bitv;
         wait_cc(HALF);
         dcap[NRISE - k] = touch_data_out;
         bcap[NRISE - k] = touch_busy;
`ifdef TOUCH_RESP_PENIRQ_EN
         pcap[NRISE - k] = touch_penirq_n;
`endif
         touch_clk = 1'b1;
         wait_cc(HALF);
         touch_clk = 1'b0;
      end
      touch_data_in = 1'b0;
      wait_cc(HALF);
   endtask

   task automatic end_xfer();
      touch_csb = 1'b1;
      wait_cc(8);
   endtask

   typedef struct {
      logic [7:0]  cmd;
      int          lead;
      logic [23:0] exp_d;
      logic [23:0] exp_b;
   } vec_t;

   vec_t tbl [5];

   initial begin
      logic [23:0] dcap, bcap, pcap;
      int s0;

      tbl[0] = '{cmd: 8'hD0, lead: 0, exp_d: 24'h0052E0, exp_b: 24'h008000}; // X 12-bit A5C
      tbl[1] = '{cmd: 8'h98, lead: 0, exp_d: 24'h001F80, exp_b: 24'h008000}; // Y 8-bit -> 3F
      tbl[2] = '{cmd: 8'hB0, lead: 3, exp_d: 24'h000001, exp_b: 24'h001000}; // Z1 after 3 zeros
      tbl[3] = '{cmd: 8'h80, lead: 0, exp_d: 24'h000000, exp_b: 24'h008000}; // unmapped
      tbl[4] = '{cmd: 8'hC0, lead: 0, exp_d: 24'h004788, exp_b: 24'h008000}; // Z2 8F1

      x_val = 12'hA5C; y_val = 12'h3F7; z1_val = 12'h001; z2_val = 12'h8F1;
      rstb = 1'b0; touch_csb = 1'b1; touch_clk = 1'b0; touch_data_in = 1'b0;
`ifdef TOUCH_RESP_PENIRQ_EN
      pen_down = 1'b1;
`endif
      wait_cc(5);
      check("reset_dout", 32'(touch_data_out), 32'd0);
      check("reset_busy", 32'(touch_busy), 32'd0);
      check("reset_last_cmd", 32'(last_cmd), 32'd0);
      check("reset_strobe", 32'(cmd_strobe), 32'd0);
      rstb = 1'b1;
      wait_cc(8);
`ifdef TOUCH_RESP_PENIRQ_EN
      check("penirq_idle_before", 32'(touch_penirq_n), 32'd0);
`endif

      for (int i = 0; i < 5; i++) begin
         s0 = strobe_cnt;
         xfer(tbl[i].cmd, tbl[i].lead, NRISE, dcap, bcap, pcap);
         check($sformatf("v%0d_dout", i), 32'(dcap), 32'(tbl[i].exp_d));
         check($sformatf("v%0d_busy", i), 32'(bcap), 32'(tbl[i].exp_b));
         check($sformatf("v%0d_last_cmd", i), 32'(last_cmd), 32'(tbl[i].cmd));
         check($sformatf("v%0d_strobes", i), 32'(strobe_cnt - s0), 32'd1);
`ifdef TOUCH_RESP_PENIRQ_EN
         if (i == 0) begin
            check("penirq_during_conv", 32'(pcap), 32'h00FFF8);
            check("penirq_idle_after", 32'(touch_penirq_n), 32'd0);
         end
`endif
         end_xfer();
      end

      // Abort after 5 command bits: partial byte dropped, outputs cleared.
      s0 = strobe_cnt;
      xfer(8'hD0, 0, 5, dcap, bcap, pcap);
      end_xfer();
      check("abort_dout", 32'(touch_data_out), 32'd0);
      check("abort_busy", 32'(touch_busy), 32'd0);
      check("abort_last_cmd", 32'(last_cmd), 32'h0000_00C0);
      check("abort_strobes", 32'(strobe_cnt - s0), 32'd0);

      // Full X read after the abort; x_val changes mid-transfer but the result is latched.
      s0 = strobe_cnt;
      fork
         xfer(8'hD0, 0, NRISE, dcap, bcap, pcap);
         begin
            wait_cc(2 * HALF * 12);
            x_val = 12'h000;
         end
      join
      check("post_abort_dout", 32'(dcap), 32'h0052E0);
      check("post_abort_busy", 32'(bcap), 32'h008000);
      check("post_abort_strobes", 32'(strobe_cnt - s0), 32'd1);
      end_xfer();
      x_val = 12'hA5C;

      // Reset while bit 6 (a one) of A5C is on DOUT.
      xfer(8'hD0, 0, 14, dcap, bcap, pcap);
      check("pre_reset_dout", 32'(touch_data_out), 32'd1);
      check("pre_reset_last_cmd", 32'(last_cmd), 32'h0000_00D0);
      rstb = 1'b0;
      wait_cc(1);
      check("mid_reset_dout", 32'(touch_data_out), 32'd0);
      check("mid_reset_busy", 32'(touch_busy), 32'd0);
      check("mid_reset_last_cmd", 32'(last_cmd), 32'd0);
      touch_csb = 1'b1;
      wait_cc(2);
      rstb = 1'b1;
      wait_cc(8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
